reply_encoder: RTL and testbench
================================

# reply_encoder

Transmit-side framer for the RS-485 link. Collects reply packets from `N_SRC` internal destinations, arbitrates between them round-robin, and serialises each packet as SYNC, DEST, LEN, payload, CHK bytes onto the byte stream that feeds the UART transmitter. It is the symmetric counterpart of the command decoder on the receive side and runs in the same `fpga_clk_48` domain.

## Interface
Parameters:
- `N_SRC`, 5, number of reply sources; DEST byte equals source index.
- `SYNC_BYTE`, 8'hAA, frame start marker.

Ports:
- `clk`  in  1  system clock (`fpga_clk_48` at top level).
- `rst`  in  1  synchronous, active-high reset.
- `src_req_bus`  in  N_SRC  per-source packet request, level, held until granted.
- `src_len_bus`  in  N_SRC*8  per-source payload length, byte i at [8i+7:8i]; stable while req high.
- `src_gnt_bus`  out  N_SRC  one-cycle grant pulse; source drops req the cycle after.
- `src_data_bus`  in  N_SRC*8  per-source payload byte.
- `src_valid_bus`  in  N_SRC  payload byte valid.
- `src_ready_bus`  out  N_SRC  payload byte accepted when valid&ready.
- `tx_data`  out  8  byte to UART.
- `tx_valid`  out  1  byte valid, held until accepted.
- `tx_ready`  in  1  UART accepts byte.
- `my_state`  out  3  debug: current state encoding.

## Operation
- States: IDLE, SYNC, DEST, LEN, PAYLOAD, CHK.
- IDLE: if any req, grant lowest index ≥ `rr_ptr` (wrapping); latch index `g` and len into `cnt`; pulse `src_gnt_bus[g]`; `rr_ptr <= g+1` mod N_SRC; go SYNC.
- SYNC/DEST/LEN: load `SYNC_BYTE`, `g`, latched len into output register; advance on load.
- PAYLOAD: `src_ready_bus[g] = (!tx_valid || tx_ready)`; all other ready bits 0. Each accepted byte loads output register, decrements `cnt`. Source may stall (valid low); encoder waits indefinitely. When last byte accepted go CHK. len=0 skips PAYLOAD (LEN → CHK).
- CHK: load XOR of DEST, LEN and all payload bytes (SYNC excluded); then IDLE.
- Output register: loads only when `!tx_valid || tx_ready`; tx_valid deasserts only after handshake with no new load.
- Checksum accumulator cleared on grant.
- Requests arriving during a packet wait; no preemption.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `src_gnt_bus`=0, `src_ready_bus`=0, state IDLE, `rr_ptr`=0, checksum 0, `my_state`=IDLE.
- Grant cycle T: gnt pulse at T; SYNC on `tx_data` with `tx_valid` at T+1.
- With `tx_ready` and `src_valid` held high: one byte per cycle, frame of len+4 bytes occupies len+4 consecutive cycles; next grant earliest in cycle after CHK handshake, so ≥1 idle cycle on tx between frames.
- `tx_ready` low: `tx_data`/`tx_valid` frozen; `src_ready_bus` low.
- Reset mid-frame: frame aborted, no CHK; source must restart on its own reset.
- len=255: counter 8-bit, no wrap issue; decrements to 0 exactly.

## Structure
- Shared package `bos_pkg`: `SYNC_BYTE`, `N_SRC`, state enum for encoder, same frame constants the command decoder uses.
- Sub-module `rr_arbiter` (N-way round-robin, req in, one-hot grant + index out, pointer update on accept).

## Test plan
- Single packet: src 2 req, len=3, data 11,22,33, tx_ready=1 → tx AA,02,03,11,22,33,01 (02^03^11^22^33=01), gnt[2] one pulse.
- len=0 from src 0 → AA,00,00,00; src_ready never high.
- Simultaneous req src 1 and 3 twice in a row after reset → order 1,3,1,3 (round-robin).
- Backpressure: tx_ready toggles 1/0 every cycle, len=4 → bytes unchanged while tx_ready=0, no drop or duplicate, correct CHK.
- Source stall: src_valid low 5 cycles mid-payload → tx_valid drops after pending byte, frame resumes intact.
- Reset asserted during PAYLOAD → next cycle tx_valid=0, state IDLE, rr_ptr 0; subsequent packet framed correctly.

Source files
------------

// File: rtl/bos_pkg.sv
// rtl/bos_pkg.sv - shared RS-485 link constants and reply encoder state encoding
package bos_pkg;

  localparam int         N_SRC          = 5;
  localparam logic [7:0] SYNC_BYTE      = 8'hAA;
  // SYNC, DEST, LEN and CHK wrap every payload on both link directions.
  localparam int         FRAME_OVERHEAD = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DEST    = 3'd2,
    ST_LEN     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CHK     = 3'd5
  } enc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin arbiter, pointer advances past the accepted winner
module rr_arbiter #(
  parameter int N = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic          any,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  // Scan from the far end so the candidate closest to ptr is assigned last and wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    gnt  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && any) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/reply_encoder.sv
// rtl/reply_encoder.sv - round-robin reply framer feeding the UART transmit byte stream
module reply_encoder #(
  parameter int         N_SRC     = bos_pkg::N_SRC,
  parameter logic [7:0] SYNC_BYTE = bos_pkg::SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src_req_bus,
  input  logic [N_SRC*8-1:0] src_len_bus,
  output logic [N_SRC-1:0]   src_gnt_bus,
  input  logic [N_SRC*8-1:0] src_data_bus,
  input  logic [N_SRC-1:0]   src_valid_bus,
  output logic [N_SRC-1:0]   src_ready_bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [2:0]         my_state
);
  import bos_pkg::enc_state_t;
  import bos_pkg::ST_IDLE;
  import bos_pkg::ST_SYNC;
  import bos_pkg::ST_DEST;
  import bos_pkg::ST_LEN;
  import bos_pkg::ST_PAYLOAD;
  import bos_pkg::ST_CHK;

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  enc_state_t       state;
  logic [IW-1:0]    g;
  logic [7:0]       cnt;
  logic [7:0]       chk;
  logic             arb_any;
  logic [N_SRC-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic [7:0]       len_arr  [N_SRC];
  logic [7:0]       data_arr [N_SRC];
  logic             can_load;
  logic             pay_take;

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign len_arr[i]  = src_len_bus[8*i +: 8];
    assign data_arr[i] = src_data_bus[8*i +: 8];
  end

  assign can_load = !tx_valid || tx_ready;
  assign my_state = state;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (src_req_bus),
    .accept (state == ST_IDLE),
    .any    (arb_any),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  // Only the granted source is offered the output register, and only while it can load.
  always_comb begin
    src_ready_bus = '0;
    if (state == ST_PAYLOAD) src_ready_bus[g] = can_load;
  end

  assign pay_take = src_valid_bus[g] && src_ready_bus[g];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      g           <= '0;
      cnt         <= '0;
      chk         <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      src_gnt_bus <= '0;
    end else begin
      src_gnt_bus <= '0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            g           <= arb_idx;
            cnt         <= len_arr[arb_idx];
            chk         <= '0;
            src_gnt_bus <= arb_gnt;
            state       <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (can_load) begin
            tx_data  <= SYNC_BYTE;
            tx_valid <= 1'b1;
            state    <= ST_DEST;
          end
        end
        ST_DEST: begin
          if (can_load) begin
            tx_data  <= 8'(g);
            tx_valid <= 1'b1;
            chk      <= chk ^ 8'(g);
            state    <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (can_load) begin
            tx_data  <= cnt;
            tx_valid <= 1'b1;
            chk      <= chk ^ cnt;
            state    <= (cnt == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pay_take) begin
            tx_data  <= data_arr[g];
            tx_valid <= 1'b1;
            chk      <= chk ^ data_arr[g];
            cnt      <= cnt - 8'd1;
            if (cnt == 8'd1) state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (can_load) begin
            tx_data  <= chk;
            tx_valid <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reply_encoder.sv
// tb/tb_reply_encoder.sv - randomized self-checking bench for reply_encoder against a frame-level model
module tb_reply_encoder;

  localparam int         N    = 5;
  localparam logic [7:0] SYNC = 8'hAA;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     src_req_bus;
  logic [N*8-1:0]   src_len_bus;
  logic [N-1:0]     src_gnt_bus;
  logic [N*8-1:0]   src_data_bus;
  logic [N-1:0]     src_valid_bus;
  logic [N-1:0]     src_ready_bus;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [2:0]       my_state;

  reply_encoder #(.N_SRC(N), .SYNC_BYTE(SYNC)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_req_bus   (src_req_bus),
    .src_len_bus   (src_len_bus),
    .src_gnt_bus   (src_gnt_bus),
    .src_data_bus  (src_data_bus),
    .src_valid_bus (src_valid_bus),
    .src_ready_bus (src_ready_bus),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .my_state      (my_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Source-side model: pending request, its length, and bytes not yet taken.
  logic [7:0] pq [N][$];
  bit         pend  [N];
  logic [7:0] plen  [N];
  int         stall [N];

  // Link-side model: bytes the UART must still see, in order.
  logic [7:0] exp_q [$];
  int         model_ptr;
  int         owner;
  int         rem;
  int         rdy_mode;
  logic [N-1:0] req_prev;
  bit         sync_due;
  bit         prev_hold;
  logic [7:0] prev_data;
  int         tx_count;
  int         gnt_idx_log [$];
  int         gnt_cyc_log [$];
  int         end_cyc_log [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit quiet();
    for (int i = 0; i < N; i++) begin
      if (pend[i] || pq[i].size() != 0) return 1'b0;
    end
    return (exp_q.size() == 0) && !tx_valid;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      plen[i]  = 8'h00;
      stall[i] = 0;
      pq[i].delete();
    end
    exp_q.delete();
    model_ptr = 0;
    owner     = -1;
    rem       = 0;
    req_prev  = '0;
    sync_due  = 1'b0;
    prev_hold = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_req_bus[i]         = pend[i];
      src_len_bus[8*i +: 8]  = plen[i];
      if (stall[i] > 0) begin
        stall[i]--;
        src_valid_bus[i]        = 1'b0;
        src_data_bus[8*i +: 8]  = 8'h00;
      end else if (pq[i].size() > 0) begin
        src_valid_bus[i]        = 1'b1;
        src_data_bus[8*i +: 8]  = pq[i][0];
      end else begin
        src_valid_bus[i]        = 1'b0;
        src_data_bus[8*i +: 8]  = 8'h00;
      end
    end
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ((cyc % 2) == 0);
      default: tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic observe();
    logic [N-1:0] allowed;
    logic [7:0]   x;
    int           e;
    if (prev_hold) check_eq("hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_data}));
    if (sync_due) begin
      check_eq("sync_lat", 32'({tx_valid, tx_data}), 32'({1'b1, SYNC}));
      sync_due = 1'b0;
    end
    allowed = '0;
    if (owner >= 0 && rem > 0 && (!tx_valid || tx_ready)) allowed[owner] = 1'b1;
    check_eq("ready_mask", 32'(src_ready_bus & ~allowed), 32'd0);

    if (src_gnt_bus != '0) begin
      e = rr_pick(req_prev, model_ptr);
      if (e < 0) begin
        check_eq("gnt_spurious", 32'(src_gnt_bus), 32'd0);
      end else begin
        check_eq("gnt", 32'(src_gnt_bus), 32'(1 << e));
        x = 8'(e) ^ plen[e];
        exp_q.push_back(SYNC);
        exp_q.push_back(8'(e));
        exp_q.push_back(plen[e]);
        for (int j = 0; j < pq[e].size(); j++) begin
          exp_q.push_back(pq[e][j]);
          x = x ^ pq[e][j];
        end
        exp_q.push_back(x);
        model_ptr = (e + 1) % N;
        pend[e]   = 1'b0;
        owner     = e;
        rem       = int'(plen[e]);
        sync_due  = !tx_valid || tx_ready;
        gnt_idx_log.push_back(e);
        gnt_cyc_log.push_back(cyc);
      end
    end

    for (int i = 0; i < N; i++) begin
      if (src_valid_bus[i] && src_ready_bus[i]) begin
        if (pq[i].size() > 0) void'(pq[i].pop_front());
        if (i == owner && rem > 0) rem--;
      end
    end

    if (tx_valid && tx_ready) begin
      tx_count++;
      check_eq("tx_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check_eq("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        if (exp_q.size() == 0) end_cyc_log.push_back(cyc);
      end
    end
    prev_hold = tx_valid && !tx_ready;
    prev_data = tx_data;
    req_prev  = src_req_bus;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    observe();
  endtask

  task automatic wait_quiet(input int budget);
    int k;
    k = 0;
    while (!quiet() && k < budget) begin
      cycle();
      k++;
    end
    check_eq("quiet", 32'(quiet()), 32'd1);
  endtask

  task automatic submit(input int s, input logic [7:0] d[$]);
    pend[s] = 1'b1;
    plen[s] = 8'(d.size());
    pq[s]   = d;
  endtask

  task automatic submit_rand(input int s, input int len);
    logic [7:0] d[$];
    for (int j = 0; j < len; j++) d.push_back(8'($urandom));
    submit(s, d);
  endtask

  task automatic clear_logs();
    gnt_idx_log.delete();
    gnt_cyc_log.delete();
    end_cyc_log.delete();
    tx_count = 0;
  endtask

  task automatic wait_payload(input int s, input int left);
    for (int k = 0; k < 100 && !(owner == s && rem <= left); k++) cycle();
    check_eq("reach_payload", 32'(owner == s && rem <= left), 32'd1);
  endtask

  initial begin
    logic [7:0] d[$];
    rst      = 1'b1;
    rdy_mode = 0;
    tx_count = 0;
    clear_model();
    drive();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_gnt", 32'(src_gnt_bus), 32'd0);
    check_eq("rst_ready", 32'(src_ready_bus), 32'd0);
    check_eq("rst_state", 32'(my_state), 32'(bos_pkg::ST_IDLE));
    rst = 1'b0;

    // Single packet from source 2.
    clear_logs();
    d = '{8'h11, 8'h22, 8'h33};
    submit(2, d);
    wait_quiet(100);
    check_eq("t1_grants", 32'(gnt_idx_log.size()), 32'd1);
    if (gnt_idx_log.size() == 1 && end_cyc_log.size() == 1)
      check_eq("t1_duration", 32'(end_cyc_log[0] - gnt_cyc_log[0]), 32'd7);
    check_eq("t1_bytes", 32'(tx_count), 32'd7);

    // Zero-length packet from source 0.
    clear_logs();
    d.delete();
    submit(0, d);
    wait_quiet(100);
    check_eq("t2_bytes", 32'(tx_count), 32'd4);
    if (end_cyc_log.size() == 1)
      check_eq("t2_duration", 32'(end_cyc_log[0] - gnt_cyc_log[0]), 32'd4);

    // Sources 1 and 3 together, twice: strict alternation and one idle cycle between frames.
    clear_logs();
    submit_rand(1, 2);
    submit_rand(3, 2);
    wait_quiet(200);
    submit_rand(1, 1);
    submit_rand(3, 1);
    wait_quiet(200);
    check_eq("t3_grants", 32'(gnt_idx_log.size()), 32'd4);
    if (gnt_idx_log.size() == 4) begin
      check_eq("t3_order0", 32'(gnt_idx_log[0]), 32'd1);
      check_eq("t3_order1", 32'(gnt_idx_log[1]), 32'd3);
      check_eq("t3_order2", 32'(gnt_idx_log[2]), 32'd1);
      check_eq("t3_order3", 32'(gnt_idx_log[3]), 32'd3);
      if (end_cyc_log.size() >= 1)
        check_eq("t3_gap", 32'(gnt_cyc_log[1] - end_cyc_log[0]), 32'd1);
    end

    // Backpressure: tx_ready alternates every cycle.
    clear_logs();
    rdy_mode = 1;
    submit_rand(4, 4);
    wait_quiet(200);
    check_eq("t4_bytes", 32'(tx_count), 32'd8);
    rdy_mode = 0;

    // Source stall of 5 cycles mid-payload.
    clear_logs();
    submit_rand(1, 10);
    wait_payload(1, 6);
    stall[1] = 5;
    repeat (3) cycle();
    check_eq("t5_stall_idle", 32'(tx_valid), 32'd0);
    wait_quiet(200);
    check_eq("t5_bytes", 32'(tx_count), 32'd14);

    // Reset in the middle of a payload from source 2 (rr pointer then sits at 3).
    clear_logs();
    submit_rand(2, 10);
    wait_payload(2, 6);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    drive();
    @(negedge clk);
    #1;
    check_eq("t6_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("t6_state", 32'(my_state), 32'(bos_pkg::ST_IDLE));
    check_eq("t6_ready", 32'(src_ready_bus), 32'd0);
    rst = 1'b0;
    clear_logs();
    submit_rand(0, 3);
    submit_rand(4, 3);
    wait_quiet(200);
    if (gnt_idx_log.size() == 2) begin
      check_eq("t6_first", 32'(gnt_idx_log[0]), 32'd0);
      check_eq("t6_second", 32'(gnt_idx_log[1]), 32'd4);
    end else begin
      check_eq("t6_grants", 32'(gnt_idx_log.size()), 32'd2);
    end

    // Maximum length frame.
    clear_logs();
    submit_rand(3, 255);
    wait_quiet(600);
    check_eq("t7_bytes", 32'(tx_count), 32'd259);
    if (end_cyc_log.size() == 1)
      check_eq("t7_duration", 32'(end_cyc_log[0] - gnt_cyc_log[0]), 32'd259);

    // Random traffic with random backpressure and source stalls.
    rdy_mode = 2;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        int s;
        s = int'($urandom_range(0, N - 1));
        if (!pend[s] && pq[s].size() == 0) submit_rand(s, int'($urandom_range(0, 12)));
      end
      if ($urandom_range(0, 30) == 0 && owner >= 0) stall[owner] = int'($urandom_range(1, 6));
      cycle();
    end
    wait_quiet(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
